pc_sequencer: RTL and testbench

//  Owns the program counter register. Each cycle it selects the next fetch

---
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter owner: picks sequential, branch or jump as the next fetch address,
// drives the PC mux select and parks a redirect that arrives while fetch cannot advance.
module pc_sequencer #(
    parameter int                 WIDTH        = 32,
    parameter int                 PC_STEP      = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             branch,
    input  logic             zero,
    input  logic             jump,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [2:0]       pc_sel,
    output logic             fetch_valid,
    output logic             flush,
    output logic             align_err
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_PEND = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pend_err_q, pend_err_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             flush_q, flush_d;
    logic             align_err_q, align_err_d;

    logic             advance;
    logic             redirect;
    logic [WIDTH-1:0] target_raw;
    logic [WIDTH-1:0] target_al;
    logic             target_mis;

    assign advance    = imem_ready & ~stall;
    assign redirect   = jump | (branch & zero);
    assign target_raw = jump ? jump_target : branch_target;
    assign target_al  = {target_raw[WIDTH-1:2], 2'b00};
    assign target_mis = |target_raw[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            pend_err_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            pend_valid_q  <= pend_valid_d;
            pend_err_q    <= pend_err_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            align_err_q   <= align_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        pend_err_d   = pend_err_q;
        flush_d      = 1'b0;
        align_err_d  = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (advance && redirect) begin
                    pc_d        = target_al;
                    flush_d     = 1'b1;
                    align_err_d = target_mis;
                end else if (advance) begin
                    pc_d = pc_q + WIDTH'(PC_STEP);
                end else if (redirect) begin
                    pend_d       = target_al;
                    pend_err_d   = target_mis;
                    pend_valid_d = 1'b1;
                    state_d      = ST_PEND;
                end else if (!imem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A redirect arriving while memory is busy wins over simply resuming.
                if (redirect) begin
                    pend_d       = target_al;
                    pend_err_d   = target_mis;
                    pend_valid_d = 1'b1;
                    state_d      = ST_PEND;
                end else if (advance) begin
                    state_d = ST_RUN;
                end
            end
            ST_PEND: begin
                if (advance && pend_valid_q) begin
                    pc_d         = pend_q;
                    flush_d      = 1'b1;
                    align_err_d  = pend_err_q;
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        fetch_valid_d = (state_d == ST_RUN);
    end

    always_comb begin
        pc_sel = 3'b000;
        if (state_q != ST_PEND) begin
            if (jump)        pc_sel = 3'b100;
            else if (branch) pc_sel = {2'b01, zero};
        end
    end

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign flush       = flush_q;
    assign align_err   = align_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios followed by random traffic,
// each checked against a cycle-level reference model of the fetch-address rules.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b1;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] jump_target = '0;
    logic [31:0] pc;
    logic [2:0]  pc_sel;
    logic        fetch_valid;
    logic        flush;
    logic        align_err;

    pc_sequencer #(.WIDTH(32), .PC_STEP(4), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .branch(branch), .zero(zero), .jump(jump),
        .branch_target(branch_target), .jump_target(jump_target),
        .pc(pc), .pc_sel(pc_sel), .fetch_valid(fetch_valid),
        .flush(flush), .align_err(align_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        fv;
        logic        fv_care;
        logic        flush;
        logic        aerr;
    } exp_t;

    exp_t       reg_q[$];
    logic [2:0] sel_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the fetch unit is doing, not how the RTL encodes it.
    localparam int M_BOOT = 0, M_RUN = 1, M_WAIT = 2, M_PEND = 3;
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic        m_fv, m_flush, m_aerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [2:0] model_sel();
        if (m_mode == M_PEND) return 3'b000;
        if (jump)             return 3'b100;
        if (branch)           return zero ? 3'b011 : 3'b010;
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_mode = M_BOOT; m_pc = 32'h0; m_pend = 32'h0;
        m_fv = 0; m_flush = 0; m_aerr = 0;
    endtask

    task automatic model_step();
        bit          adv, red;
        logic [31:0] tgt;
        adv = imem_ready && !stall;
        red = jump || (branch && zero);
        tgt = jump ? jump_target : branch_target;
        m_flush = 0; m_aerr = 0;
        if (m_mode == M_BOOT) m_mode = M_RUN;
        else if (m_mode == M_RUN) begin
            if (adv && red) begin
                m_pc = tgt & ~32'h3; m_flush = 1; m_aerr = (tgt % 4) != 0;
            end else if (adv) m_pc = m_pc + 32'd4;
            else if (red) begin m_pend = tgt; m_mode = M_PEND; end
            else if (!imem_ready) m_mode = M_WAIT;
        end else if (m_mode == M_WAIT) begin
            if (red) begin m_pend = tgt; m_mode = M_PEND; end
            else if (adv) m_mode = M_RUN;
        end else begin
            if (adv) begin
                m_pc = m_pend & ~32'h3; m_flush = 1; m_aerr = (m_pend % 4) != 0;
                m_mode = M_RUN;
            end
        end
        m_fv = (m_mode == M_RUN);
    endtask

    task automatic push_reg(input int tag);
        exp_t e;
        e.cyc = tag; e.pc = m_pc; e.fv = m_fv; e.fv_care = (m_mode != M_PEND);
        e.flush = m_flush; e.aerr = m_aerr;
        reg_q.push_back(e);
    endtask

    task automatic cycle(input bit s, input bit r, input bit b, input bit z, input bit j,
                         input logic [31:0] bt, input logic [31:0] jt);
        @(posedge clk); #1;
        stall = s; imem_ready = r; branch = b; zero = z; jump = j;
        branch_target = bt; jump_target = jt;
        sel_q.push_back(model_sel());
        model_step();
        push_reg(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1;
        stall = 0; imem_ready = 1; branch = 0; zero = 0; jump = 0;
        branch_target = '0; jump_target = '0;
        reg_q.delete(); sel_q.delete();
        model_reset();
        sel_q.push_back(model_sel());
        push_reg(cyc);
        #2 reset = 0;
        model_step();
        push_reg(cyc + 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sel_q.size() > 0) chk("pc_sel", 32'(pc_sel), 32'(sel_q.pop_front()));
            if (reg_q.size() > 0 && reg_q[0].cyc == cyc) begin
                e = reg_q.pop_front();
                chk("pc", pc, e.pc);
                if (e.fv_care) chk("fetch_valid", 32'(fetch_valid), 32'(e.fv));
                chk("flush", 32'(flush), 32'(e.flush));
                chk("align_err", 32'(align_err), 32'(e.aerr));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit          s, r, b, z, j;
        logic [31:0] bt, jt;
        model_reset();
        do_reset();
        idle(3);                                       // pc 0,0,4,8
        cycle(0, 1, 0, 0, 1, 32'h0, 32'h40);           // jump to 0x40
        cycle(0, 1, 1, 0, 0, 32'h999, 32'h0);          // branch not taken
        cycle(0, 1, 1, 1, 0, 32'h80, 32'h0);           // branch taken
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1, 32'h0, 32'h100);
        cycle(1, 1, 0, 0, 1, 32'h0, 32'h200);          // ignored, first redirect wins
        idle(3);
        cycle(0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle(0, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(3);
        cycle(0, 1, 0, 0, 1, 32'h0, 32'h43);           // misaligned target
        idle(1);
        cycle(1, 1, 0, 0, 1, 32'h0, 32'h60);           // park a redirect
        cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);
        do_reset();                                    // pending redirect must vanish
        idle(4);
        cycle(0, 1, 0, 0, 1, 32'h0, 32'hFFFF_FFF8);    // wrap-around
        idle(4);
        cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);            // stall and not-ready together
        cycle(1, 1, 0, 0, 0, 32'h0, 32'h0);
        cycle(0, 0, 1, 1, 0, 32'h123, 32'h0);          // redirect while waiting
        idle(2);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
            end else begin
                s  = ($urandom_range(3) == 0);
                r  = ($urandom_range(4) != 0);
                b  = ($urandom_range(3) == 0);
                z  = $urandom_range(1);
                j  = ($urandom_range(7) == 0);
                bt = $urandom;
                jt = $urandom;
                cycle(s, r, b, z, j, bt, jt);
            end
        end
        idle(2);
        @(posedge clk); @(posedge clk); #1;
        chk("scoreboard_drained", 32'(reg_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
